// File: rtl/h264invdcchroma_pkg.sv
// Shared types, constants and helpers for the chroma DC
// inverse transform and dequantisation path.
package h264_dc_pkg;

    localparam int IN_W   = 16;
    localparam int SUM_W  = 18;
    localparam int PROD_W = 36;

    localparam logic [5:0] QP_MAX = 6'd51;

    localparam logic [4:0] LS_DC [6] = '{
        5'd10, 5'd11, 5'd13, 5'd14, 5'd16, 5'd18
    };

    localparam logic signed [PROD_W-1:0] SAT_MAX = 36'sd32767;
    localparam logic signed [PROD_W-1:0] SAT_MIN = -36'sd32768;

    typedef enum logic [1:0] {
        LOAD,
        XFORM,
        SCALE,
        OUT
    } state_t;

    typedef struct packed {
        logic [3:0] div;
        logic [2:0] rem;
    } qp_split_t;

    function automatic logic [5:0] qp_clamp(input logic [5:0] qp);
        return (qp > QP_MAX) ? QP_MAX : qp;
    endfunction

    // Compare ladder instead of a divider; qp is already clamped.
    function automatic qp_split_t qp_split(input logic [5:0] qp);
        qp_split_t r;
        r.div = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if (qp >= 6'(6 * k)) r.div = 4'(k);
        end
        r.rem = 3'(qp - 6'(r.div) * 6'd6);
        return r;
    endfunction

    function automatic logic [4:0] ls_dc(input logic [2:0] rem);
        case (rem)
            3'd0:    return LS_DC[0];
            3'd1:    return LS_DC[1];
            3'd2:    return LS_DC[2];
            3'd3:    return LS_DC[3];
            3'd4:    return LS_DC[4];
            default: return LS_DC[5];
        endcase
    endfunction

    function automatic logic signed [IN_W-1:0] sat16(
        input logic signed [PROD_W-1:0] v
    );
        if (v > SAT_MAX) return 16'sh7fff;
        if (v < SAT_MIN) return 16'sh8000;
        return v[IN_W-1:0];
    endfunction

endpackage

// File: rtl/h264invdcchroma_if.sv
// Input beat stream (ENABLE/READYI) and output beat
// stream (VALID/READYO) of the chroma DC block.
interface h264invdcchroma_if;
    logic               READYI;
    logic               ENABLE;
    logic signed [15:0] XXIN;
    logic [5:0]         QP;
    logic               VALID;
    logic signed [15:0] YYOUT;
    logic               READYO;

    modport slave (
        output READYI, VALID, YYOUT,
        input  ENABLE, XXIN, QP, READYO
    );

    modport master (
        input  READYI, VALID, YYOUT,
        output ENABLE, XXIN, QP, READYO
    );
endinterface

// File: rtl/h264invdcchroma_dequant.sv
// One coefficient: scale by LS, shift by qp/6, halve with
// floor rounding, saturate to 16 bits. Purely combinational.
module h264dcdequant
    import h264_dc_pkg::*;
(
    input  logic signed [SUM_W-1:0] i_f,
    input  logic [4:0]              i_ls,
    input  logic [3:0]              i_sh,
    output logic signed [IN_W-1:0]  o_d
);

    logic signed [PROD_W-1:0] w_f_ext;
    logic signed [PROD_W-1:0] w_ls_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shl;
    logic signed [PROD_W-1:0] w_half;

    assign w_f_ext  = {{(PROD_W-SUM_W){i_f[SUM_W-1]}}, i_f};
    assign w_ls_ext = {{(PROD_W-5){1'b0}}, i_ls};
    assign w_prod   = w_f_ext * w_ls_ext;
    assign w_shl    = w_prod <<< i_sh;
    assign w_half   = w_shl >>> 1;
    assign o_d      = sat16(w_half);

endmodule

// File: rtl/h264invdcchroma.sv
// Chroma DC reconstruction: 4 input beats, 2x2 inverse
// Hadamard, per-QP dequantisation, 4 output beats.
module h264invdcchroma
    import h264_dc_pkg::*;
#(
    parameter bit TOGETHER = 1'b0
) (
    input logic                CLK2,
    input logic                RESET,
    h264invdcchroma_if.slave   io
);

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_idx;
    logic signed [IN_W-1:0]  r_c00;
    logic signed [IN_W-1:0]  r_c10;
    logic signed [SUM_W-1:0] r_a0;
    logic signed [SUM_W-1:0] r_a1;
    logic signed [SUM_W-1:0] r_b0;
    logic signed [SUM_W-1:0] r_b1;
    logic signed [SUM_W-1:0] r_f [4];
    logic signed [IN_W-1:0]  r_d [4];
    logic signed [IN_W-1:0]  w_d [4];
    logic [3:0]              r_qdiv;
    logic [2:0]              r_qrem;
    logic                    r_valid;
    logic signed [IN_W-1:0]  r_yy;
    logic                    w_readyi;
    logic                    w_accept;
    logic                    w_fire;
    logic [4:0]              w_ls;
    qp_split_t               w_qps;

    assign w_readyi  = (r_state == LOAD) && !RESET;
    assign w_accept  = w_readyi && io.ENABLE;
    assign w_fire    = (r_state == OUT) &&
                       (io.READYO || (TOGETHER && r_idx != 2'd0));
    assign w_qps     = qp_split(qp_clamp(io.QP));
    assign w_ls      = ls_dc(r_qrem);
    assign io.READYI = w_readyi;
    assign io.VALID  = r_valid;
    assign io.YYOUT  = r_yy;

    // State register; reset aborts any block in flight.
    always_ff @(posedge CLK2) begin
        if (RESET) r_state <= LOAD;
        else       r_state <= w_next;
    end

    // Next-state: 4 input beats, 2 compute cycles, 4 output beats.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LOAD:  if (w_accept && r_idx == 2'd3) w_next = XFORM;
            XFORM: w_next = SCALE;
            SCALE: w_next = OUT;
            OUT:   if (w_fire && r_idx == 2'd3) w_next = LOAD;
        endcase
    end

    // Beat index is shared by the input and output phases.
    always_ff @(posedge CLK2) begin
        if (RESET)                  r_idx <= 2'd0;
        else if (w_accept || w_fire) r_idx <= r_idx + 2'd1;
    end

    // Input beats build the row butterflies as they arrive.
    always_ff @(posedge CLK2) begin
        if (w_accept) begin
            unique case (r_idx)
                2'd0: begin
                    r_c00  <= io.XXIN;
                    r_qdiv <= w_qps.div;
                    r_qrem <= w_qps.rem;
                end
                2'd1: begin
                    r_a0 <= SUM_W'(r_c00) + SUM_W'(io.XXIN);
                    r_a1 <= SUM_W'(r_c00) - SUM_W'(io.XXIN);
                end
                2'd2: r_c10 <= io.XXIN;
                2'd3: begin
                    r_b0 <= SUM_W'(r_c10) + SUM_W'(io.XXIN);
                    r_b1 <= SUM_W'(r_c10) - SUM_W'(io.XXIN);
                end
            endcase
        end
    end

    // Column butterflies in XFORM, dequantised results in SCALE.
    always_ff @(posedge CLK2) begin
        if (r_state == XFORM) begin
            r_f[0] <= r_a0 + r_b0;
            r_f[1] <= r_a1 + r_b1;
            r_f[2] <= r_a0 - r_b0;
            r_f[3] <= r_a1 - r_b1;
        end
        if (r_state == SCALE) begin
            for (int k = 0; k < 4; k++) r_d[k] <= w_d[k];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dq
        h264dcdequant u_dq (
            .i_f  (r_f[g]),
            .i_ls (w_ls),
            .i_sh (r_qdiv),
            .o_d  (w_d[g])
        );
    end

    // Output beat register; holds data while stalled.
    always_ff @(posedge CLK2) begin
        if (RESET) begin
            r_valid <= 1'b0;
            r_yy    <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_yy    <= r_d[r_idx];
        end else begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_h264invdcchroma.sv
// Scoreboard bench: two instances (TOGETHER=0 and 1) share
// stimulus; a reference model predicts every output beat.
module tb_h264invdcchroma;

    logic        CLK2 = 1'b0;
    logic        RESET = 1'b1;
    logic        tb_en = 1'b0;
    logic [15:0] tb_x = '0;
    logic [5:0]  tb_qp = '0;
    logic        tb_ro = 1'b1;
    logic        ro_rand = 1'b0;
    logic        mon_en = 1'b0;

    int total = 0;
    int bad = 0;
    int sb0[$];
    int sb1[$];
    int bcnt[2] = '{0, 0};
    int lastyy[2] = '{0, 0};
    int nbeats[2] = '{0, 0};
    int LS_T[6] = '{10, 11, 13, 14, 16, 18};

    logic               vld[2];
    logic               rdy[2];
    logic signed [15:0] yy[2];

    h264invdcchroma_if if0 ();
    h264invdcchroma_if if1 ();

    assign if0.ENABLE = tb_en;
    assign if0.XXIN   = tb_x;
    assign if0.QP     = tb_qp;
    assign if0.READYO = tb_ro;
    assign if1.ENABLE = tb_en;
    assign if1.XXIN   = tb_x;
    assign if1.QP     = tb_qp;
    assign if1.READYO = tb_ro;
    assign vld[0] = if0.VALID;
    assign vld[1] = if1.VALID;
    assign rdy[0] = if0.READYI;
    assign rdy[1] = if1.READYI;
    assign yy[0]  = if0.YYOUT;
    assign yy[1]  = if1.YYOUT;

    h264invdcchroma #(.TOGETHER(1'b0)) u_dut0 (
        .CLK2  (CLK2),
        .RESET (RESET),
        .io    (if0.slave)
    );

    h264invdcchroma #(.TOGETHER(1'b1)) u_dut1 (
        .CLK2  (CLK2),
        .RESET (RESET),
        .io    (if1.slave)
    );

    always #5 CLK2 = ~CLK2;

    always @(negedge CLK2) begin
        if (ro_rand) tb_ro = 1'($urandom_range(0, 1));
    end

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int sb_size(int k);
        if (k == 0) return sb0.size();
        return sb1.size();
    endfunction

    function automatic int sb_pop(int k);
        if (k == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    // Reference: d = floor(f * LS * 2^(qp/6) / 2), clipped.
    function automatic int ref_d(int f, int qp);
        int     q;
        longint p;
        longint h;
        q = (qp > 51) ? 51 : qp;
        p = longint'(f) * LS_T[q % 6] * (longint'(1) << (q / 6));
        h = (p >= 0) ? p / 2 : -((-p + 1) / 2);
        if (h > 32767) h = 32767;
        if (h < -32768) h = -32768;
        return int'(h);
    endfunction

    task automatic push_ref(int qp, int c[4]);
        int f[4];
        f[0] = c[0] + c[1] + c[2] + c[3];
        f[1] = c[0] - c[1] + c[2] - c[3];
        f[2] = c[0] + c[1] - c[2] - c[3];
        f[3] = c[0] - c[1] - c[2] + c[3];
        for (int k = 0; k < 4; k++) begin
            sb0.push_back(ref_d(f[k], qp));
            sb1.push_back(ref_d(f[k], qp));
        end
    endtask

    // Monitor: pop and compare on every VALID beat.
    always @(posedge CLK2) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!mon_en) begin
                bcnt[k] = 0;
            end else if (vld[k]) begin
                if (sb_size(k) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra beat dut%0d: got %0d want none",
                             k, int'(yy[k]));
                end else begin
                    check($sformatf("data dut%0d", k),
                          int'(yy[k]), sb_pop(k));
                end
                if (bcnt[k] != 3)
                    check("readyi in out", int'(rdy[k]), 0);
                bcnt[k] = (bcnt[k] + 1) % 4;
                lastyy[k] = int'(yy[k]);
                nbeats[k]++;
            end else if (bcnt[k] != 0) begin
                check("hold data", int'(yy[k]), lastyy[k]);
                check("readyi stall", int'(rdy[k]), 0);
            end
        end
    end

    task automatic send(int qp, int c0, int c1, int c2, int c3,
                        int nb, bit keep_en, bit gaps);
        int c[4];
        int b;
        int guard;
        bit acc;
        c = '{c0, c1, c2, c3};
        b = 0;
        guard = 0;
        while (b < nb) begin
            @(negedge CLK2);
            if (gaps && $urandom_range(0, 3) == 0) begin
                tb_en = 1'b0;
                @(posedge CLK2);
            end else begin
                tb_en = 1'b1;
                tb_x  = 16'(c[b]);
                tb_qp = 6'(qp);
                #1;
                acc = rdy[0];
                @(posedge CLK2);
                if (acc) b++;
            end
            guard++;
            if (guard > 300) begin
                total++;
                bad++;
                $display("FAIL send timeout: beat %0d want 4", b);
                break;
            end
        end
        #1;
        if (!keep_en) tb_en = 1'b0;
        if (nb == 4 && b == 4) push_ref(qp, c);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && g < 400) begin
            @(posedge CLK2);
            g++;
        end
        if (g >= 400) begin
            total++;
            bad++;
            $display("FAIL drain timeout: left %0d/%0d want 0",
                     sb0.size(), sb1.size());
        end
        @(negedge CLK2);
    endtask

    task automatic do_reset();
        @(negedge CLK2);
        RESET  = 1'b1;
        tb_en  = 1'b0;
        mon_en = 1'b0;
        sb0.delete();
        sb1.delete();
        #1;
        check("readyi during reset", int'(rdy[0]), 0);
        @(posedge CLK2);
        #1;
        check("valid0 after reset", int'(vld[0]), 0);
        check("valid1 after reset", int'(vld[1]), 0);
        check("yy0 after reset", int'(yy[0]), 0);
        check("yy1 after reset", int'(yy[1]), 0);
        @(negedge CLK2);
        RESET = 1'b0;
        #1;
        check("readyi0 released", int'(rdy[0]), 1);
        check("readyi1 released", int'(rdy[1]), 1);
        mon_en = 1'b1;
    endtask

    function automatic int rnd16();
        logic [15:0] u;
        case ($urandom_range(0, 5))
            0: return 32767;
            1: return -32768;
            2: return int'($urandom_range(0, 20)) - 10;
            default: begin
                u = 16'($urandom);
                return int'($signed(u));
            end
        endcase
    endfunction

    initial begin
        int n0;
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};

        do_reset();

        send(0, 4, 0, 0, 0, 4, 1'b0, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(posedge CLK2);
            #1;
            check($sformatf("latency edge %0d", e),
                  int'(vld[0]), (e == 3) ? 1 : 0);
        end
        check("first beat value", int'(yy[0]), 20);
        drain();

        send(0, 1, 1, 1, 1, 4, 1'b0, 1'b1);
        send(6, 4, 0, 0, 0, 4, 1'b0, 1'b1);
        send(51, 1, 0, 0, 0, 4, 1'b0, 1'b0);
        send(0, -3, 0, 0, 0, 4, 1'b0, 1'b0);
        send(51, 32767, 32767, 32767, 32767, 4, 1'b0, 1'b0);
        send(51, -32768, -32768, -32768, -32768, 4, 1'b0, 1'b0);
        send(63, 1, 0, 0, 0, 4, 1'b0, 1'b0);
        send(63, 7, -5, 3, 2, 4, 1'b0, 1'b0);
        drain();

        n0 = nbeats[0];
        send(0, 5, -2, 7, 3, 4, 1'b0, 1'b0);
        @(negedge CLK2);
        tb_ro = 1'b0;
        @(negedge CLK2);
        tb_ro = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK2);
            tb_ro = 1'(pat[i]);
        end
        @(posedge CLK2);
        #2;
        check("toggle queue empty", sb0.size(), 0);
        check("toggle beat count", nbeats[0] - n0, 4);
        @(negedge CLK2);
        tb_ro = 1'b1;
        drain();

        send(12, 100, -50, 25, 9, 4, 1'b0, 1'b0);
        @(negedge CLK2);
        tb_ro = 1'b0;
        @(negedge CLK2);
        tb_ro = 1'b0;
        @(negedge CLK2);
        tb_ro = 1'b1;
        @(posedge CLK2);
        #1;
        check("together beat 0", int'(vld[1]), 1);
        @(negedge CLK2);
        tb_ro = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(posedge CLK2);
            #1;
            check($sformatf("together beat %0d", i), int'(vld[1]), 1);
        end
        #1;
        check("together queue empty", sb1.size(), 0);
        check("stalled dut0 left", sb0.size(), 3);
        @(negedge CLK2);
        tb_ro = 1'b1;
        drain();

        send(9, 11, 22, 33, 44, 3, 1'b0, 1'b0);
        do_reset();
        send(0, 4, 0, 0, 0, 4, 1'b0, 1'b0);
        drain();

        send(30, -700, 1200, 5, -9, 4, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) @(posedge CLK2);
        #1;
        check("beat1 before abort", int'(vld[0]), 1);
        do_reset();
        send(0, 4, 0, 0, 0, 4, 1'b0, 1'b0);
        drain();

        n0 = nbeats[0];
        send(20, 9, 8, 7, 6, 4, 1'b1, 1'b0);
        send(21, -1, -2, -3, -4, 4, 1'b0, 1'b0);
        drain();
        check("held enable beats", nbeats[0] - n0, 8);

        ro_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 63)), rnd16(), rnd16(),
                 rnd16(), rnd16(), 4, 1'b0, 1'b1);
            drain();
        end
        ro_rand = 1'b0;
        tb_ro = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

endmodule
